// File: rtl/gf_reduce_seq.sv
// Sequential GF(2) polynomial reduction: reduces a 2M-1-bit product modulo an
// (M+1)-bit polynomial, STEP bit positions per clock, with valid/ready handshakes.
module gf_reduce_seq #(
   parameter int M    = 8,
   parameter int STEP = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*M-2:0] in_poly,
   input  logic [M:0]     modulus,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M-1:0]   out_rem,
   output logic           out_err
);

   localparam int WW = 2*M-1;
   localparam int JW = $clog2(2*M);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REDUCE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [WW-1:0] w_reg, w_next;
   logic [M:0]    p_reg, p_next;
   logic [JW-1:0] j_reg, j_next;
   logic [M-1:0]  rem_reg, rem_next;
   logic          err_reg, err_next;

   logic [WW-1:0] p_ext;
   logic [WW-1:0] w_step;
   logic          last_step;

   assign p_ext = WW'(p_reg);

   // One clock of reduction: positions j down to j-STEP+1, each seeing the
   // work register as already updated by the higher positions.
   always_comb begin
      w_step = w_reg;
      for (int s = 0; s < STEP; s++) begin
         for (int k = M; k < WW; k++) begin
            if ((int'(j_reg) - s == k) && w_step[k]) begin
               w_step = w_step ^ (p_ext << (k - M));
            end
         end
      end
   end

   // The step that covers position M is the final one.
   assign last_step = (int'(j_reg) < M + STEP);

   always_comb begin
      state_next = state_reg;
      w_next     = w_reg;
      p_next     = p_reg;
      j_next     = j_reg;
      rem_next   = rem_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               w_next   = in_poly;
               p_next   = modulus;
               rem_next = '0;
               if (modulus[M]) begin
                  state_next = REDUCE;
                  j_next     = JW'(WW - 1);
                  err_next   = 1'b0;
               end else begin
                  state_next = DONE;
                  j_next     = '0;
                  err_next   = 1'b1;
               end
            end
         end
         REDUCE: begin
            w_next = w_step;
            j_next = j_reg - JW'(STEP);
            if (last_step) begin
               state_next = DONE;
               rem_next   = w_step[M-1:0];
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         w_reg     <= '0;
         p_reg     <= '0;
         j_reg     <= '0;
         rem_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         w_reg     <= w_next;
         p_reg     <= p_next;
         j_reg     <= j_next;
         rem_reg   <= rem_next;
         err_reg   <= err_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_rem   = rem_reg;
   assign out_err   = err_reg;

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Bench for gf_reduce_seq: three instances (STEP = 1, 3, 7) share stimulus and
// are checked against a long-division reference model and expected latencies.
module tb_gf_reduce_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [14:0] in_poly;
   logic [8:0]  modulus;

   logic [2:0]  in_ready_w;
   logic [2:0]  out_valid_w;
   logic [2:0]  out_err_w;
   logic [7:0]  out_rem_w [3];

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [7:0] rem;
      logic       err;
      logic [2:0][7:0] lat;
   } exp_t;

   exp_t sbq[$];

   gf_reduce_seq #(.M(8), .STEP(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_poly(in_poly), .modulus(modulus), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .out_rem(out_rem_w[0]), .out_err(out_err_w[0]));

   gf_reduce_seq #(.M(8), .STEP(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_poly(in_poly), .modulus(modulus), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .out_rem(out_rem_w[1]), .out_err(out_err_w[1]));

   gf_reduce_seq #(.M(8), .STEP(7)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_poly(in_poly), .modulus(modulus), .out_valid(out_valid_w[2]),
      .out_ready(out_ready), .out_rem(out_rem_w[2]), .out_err(out_err_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Polynomial long division over GF(2).
   function automatic logic [7:0] gf_mod(input logic [14:0] poly, input logic [8:0] md);
      logic [14:0] w;
      if (!md[8]) return 8'h00;
      w = poly;
      for (int k = 14; k >= 8; k--)
         if (w[k]) w = w ^ (15'(md) << (k - 8));
      return w[7:0];
   endfunction

   // Latency counted with the accept edge as edge 1: C+1 for a legal modulus.
   function automatic exp_t make_exp(input logic [14:0] poly, input logic [8:0] md);
      exp_t e;
      e.rem = gf_mod(poly, md);
      e.err = ~md[8];
      e.lat[0] = md[8] ? 8'd8 : 8'd1;
      e.lat[1] = md[8] ? 8'd4 : 8'd1;
      e.lat[2] = md[8] ? 8'd2 : 8'd1;
      return e;
   endfunction

   // Issues one operand to all instances with out_ready=1 and collects results.
   task automatic do_op(input logic [14:0] poly, input logic [8:0] md,
                        output logic [2:0][7:0] rems, output logic [2:0] errs,
                        output logic [2:0][7:0] lats);
      logic [2:0] seen;
      seen = 3'b000;
      rems = '0;
      errs = '0;
      lats = {3{8'hFF}};
      out_ready = 1'b1;
      @(negedge clk);
      in_poly  = poly;
      modulus  = md;
      in_valid = 1'b1;
      for (int e = 1; e <= 20 && seen != 3'b111; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            in_valid = 1'b0;
            in_poly  = 15'($urandom);
            modulus  = 9'($urandom);
         end
         for (int d = 0; d < 3; d++) begin
            if (!seen[d] && out_valid_w[d]) begin
               seen[d] = 1'b1;
               lats[d] = 8'(e);
               rems[d] = out_rem_w[d];
               errs[d] = out_err_w[d];
            end
         end
      end
      @(posedge clk); #1;
      $display("op poly=%h mod=%h -> rem %h/%h/%h err %b lat %0d/%0d/%0d",
               poly, md, rems[0], rems[1], rems[2], errs, lats[0], lats[1], lats[2]);
   endtask

   task automatic test_reset;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_poly = '0; modulus = '0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (in_ready_w !== 3'b111) $display("FAIL reset_in_ready got %b want 111", in_ready_w); else passed++;
      total++; if (out_valid_w !== 3'b000) $display("FAIL reset_out_valid got %b want 000", out_valid_w); else passed++;
      total++; if (out_err_w !== 3'b000) $display("FAIL reset_out_err got %b want 000", out_err_w); else passed++;
      total++; if (out_rem_w[0] !== 8'h00) $display("FAIL reset_out_rem got %h want 00", out_rem_w[0]); else passed++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [2:0][7:0] rems, lats;
      logic [2:0] errs;
      exp_t ex;
      sbq.push_back(make_exp(15'h2B79, 9'h11B));
      do_op(15'h2B79, 9'h11B, rems, errs, lats);
      ex = sbq.pop_front();
      total++; if (rems[0] !== 8'hC1) $display("FAIL basic_known_rem got %h want c1", rems[0]); else passed++;
      for (int d = 0; d < 3; d++) begin
         total++; if (rems[d] !== ex.rem) $display("FAIL basic_rem%0d got %h want %h", d, rems[d], ex.rem); else passed++;
         total++; if (lats[d] !== ex.lat[d]) $display("FAIL basic_lat%0d got %0d want %0d", d, lats[d], ex.lat[d]); else passed++;
         total++; if (errs[d] !== ex.err) $display("FAIL basic_err%0d got %b want %b", d, errs[d], ex.err); else passed++;
      end
   endtask

   task automatic test_low_poly;
      logic [2:0][7:0] rems, lats;
      logic [2:0] errs;
      exp_t ex;
      sbq.push_back(make_exp(15'h00A5, 9'h11B));
      do_op(15'h00A5, 9'h11B, rems, errs, lats);
      ex = sbq.pop_front();
      for (int d = 0; d < 3; d++) begin
         total++; if (rems[d] !== 8'hA5) $display("FAIL low_rem%0d got %h want a5", d, rems[d]); else passed++;
         total++; if (lats[d] !== ex.lat[d]) $display("FAIL low_lat%0d got %0d want %0d", d, lats[d], ex.lat[d]); else passed++;
      end
   endtask

   task automatic test_err;
      logic [2:0][7:0] rems, lats;
      logic [2:0] errs;
      exp_t ex;
      sbq.push_back(make_exp(15'h2B79, 9'h01B));
      do_op(15'h2B79, 9'h01B, rems, errs, lats);
      ex = sbq.pop_front();
      for (int d = 0; d < 3; d++) begin
         total++; if (errs[d] !== ex.err) $display("FAIL err_flag%0d got %b want %b", d, errs[d], ex.err); else passed++;
         total++; if (rems[d] !== ex.rem) $display("FAIL err_rem%0d got %h want %h", d, rems[d], ex.rem); else passed++;
         total++; if (lats[d] !== ex.lat[d]) $display("FAIL err_lat%0d got %0d want %0d", d, lats[d], ex.lat[d]); else passed++;
      end
   endtask

   task automatic test_random;
      logic [2:0][7:0] rems, lats;
      logic [2:0] errs;
      logic [14:0] p;
      logic [8:0]  md;
      exp_t ex;
      for (int i = 0; i < 6; i++) begin
         p  = 15'($urandom);
         md = {1'b1, 8'($urandom)};
         sbq.push_back(make_exp(p, md));
         do_op(p, md, rems, errs, lats);
         ex = sbq.pop_front();
         for (int d = 0; d < 3; d++) begin
            total++; if (rems[d] !== ex.rem) $display("FAIL rand%0d_rem%0d got %h want %h", i, d, rems[d], ex.rem); else passed++;
         end
         total++; if (lats[0] !== ex.lat[0]) $display("FAIL rand%0d_lat got %0d want %0d", i, lats[0], ex.lat[0]); else passed++;
      end
   endtask

   task automatic test_backpressure;
      bit all_valid;
      all_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      in_poly = 15'h2B79; modulus = 9'h11B; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 0; e < 20 && !all_valid; e++) begin
         @(negedge clk);
         in_poly = 15'($urandom); modulus = 9'($urandom);
         @(posedge clk); #1;
         all_valid = (out_valid_w == 3'b111);
      end
      total++; if (!all_valid) $display("FAIL hold_reach_done got %b want 111", out_valid_w); else passed++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = ~in_valid; in_poly = 15'($urandom); modulus = 9'h11B;
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            total++; if (out_rem_w[d] !== 8'hC1) $display("FAIL hold%0d_rem%0d got %h want c1", c, d, out_rem_w[d]); else passed++;
         end
         total++; if (in_ready_w !== 3'b000) $display("FAIL hold%0d_in_ready got %b want 000", c, in_ready_w); else passed++;
         total++; if (out_valid_w !== 3'b111) $display("FAIL hold%0d_out_valid got %b want 111", c, out_valid_w); else passed++;
      end
      $display("hold: rem %h/%h/%h held 5 cycles", out_rem_w[0], out_rem_w[1], out_rem_w[2]);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid_w !== 3'b000) $display("FAIL drain_out_valid got %b want 000", out_valid_w); else passed++;
      total++; if (in_ready_w !== 3'b111) $display("FAIL drain_in_ready got %b want 111", in_ready_w); else passed++;
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      logic [2:0][7:0] rems, lats;
      logic [2:0] errs;
      bit leaked;
      exp_t ex;
      leaked = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      in_poly = 15'h2B79; modulus = 9'h11B; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (out_valid_w !== 3'b000) $display("FAIL abort_out_valid got %b want 000", out_valid_w); else passed++;
      total++; if (in_ready_w !== 3'b111) $display("FAIL abort_in_ready got %b want 111", in_ready_w); else passed++;
      total++; if (out_rem_w[1] !== 8'h00) $display("FAIL abort_rem got %h want 00", out_rem_w[1]); else passed++;
      @(negedge clk) rst_n = 1'b1;
      for (int e = 0; e < 12; e++) begin
         @(posedge clk); #1;
         if (out_valid_w[0]) leaked = 1'b1;
      end
      total++; if (leaked !== 1'b0) $display("FAIL abort_no_result got %b want 0", leaked); else passed++;
      $display("abort: reset mid-reduction, result emitted=%b", leaked);
      sbq.push_back(make_exp(15'h2B79, 9'h11B));
      do_op(15'h2B79, 9'h11B, rems, errs, lats);
      ex = sbq.pop_front();
      for (int d = 0; d < 3; d++) begin
         total++; if (rems[d] !== ex.rem) $display("FAIL abort_next_rem%0d got %h want %h", d, rems[d], ex.rem); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_low_poly();
      test_err();
      test_random();
      test_backpressure();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout: got no completion want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gf_reduce_seq.md
GF_REDUCE_SEQ -- requirements
Module: gf_reduce_seq

Interface
REQ-001 SHALL have parameter M, default 8: field degree; legal range 2..32.
REQ-002 SHALL have parameter STEP, default 1: product bits reduced per clock; legal range 1..M-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_poly  input  2M-1  unreduced product polynomial; bit i is the coefficient of x^i.
REQ-008 SHALL have port modulus  input  M+1  reduction polynomial; bit M must be 1.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_rem  output  M  remainder of in_poly mod modulus over GF(2).
REQ-012 SHALL have port out_err  output  1  operand was rejected because modulus[M]==0; qualified by out_valid.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, REDUCE, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept = in_valid & in_ready on a rising edge: latch in_poly into a 2M-1-bit work register W and modulus into a modulus register P.
REQ-016 On accept with modulus[M]==1: go to REDUCE, load pointer j = 2M-2.
REQ-017 On accept with modulus[M]==0: go directly to DONE with out_err=1 and out_rem=0; no reduction cycles.
REQ-018 Each REDUCE edge SHALL process bit positions j, j-1, ... j-STEP+1 in descending order, skipping any position below M: if W[k]==1 then W ^= P << (k-M), using W as updated by the higher positions in the same step.
REQ-019 After each REDUCE edge, j SHALL decrease by STEP; the FSM SHALL enter DONE on the edge that processes position M.
REQ-020 REDUCE SHALL last exactly C = ceil((M-1)/STEP) edges; out_valid SHALL rise C+1 edges after the accept edge.
REQ-021 In DONE: out_rem = W[M-1:0], out_err = 0 for a legal modulus; W[2M-2:M] SHALL be zero.
REQ-022 out_rem and out_err SHALL remain stable while out_valid=1 and out_ready=0, for any duration.
REQ-023 On out_valid & out_ready: return to IDLE; in_ready is first 1 on the following cycle, so no same-edge result drain and operand accept.
REQ-024 in_valid, in_poly and modulus SHALL be ignored outside IDLE; changes to them during REDUCE SHALL NOT affect the result.
REQ-025 An in_poly with no bits set at or above M SHALL still take C REDUCE edges and return out_rem = in_poly[M-1:0].
REQ-026 out_rem and out_err SHALL be driven from registers, with no combinational path from any input.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, W=0, P=0, j=0, out_valid=0, out_rem=0, out_err=0, and in_ready=1.
REQ-028 Reset asserted during REDUCE or DONE SHALL abort the operation with no result emitted; the first accept after release SHALL start a fresh reduction.

Verification
REQ-029 M=8, STEP=1, modulus=0x11B, in_poly=0x2B79, out_ready=1 -> out_rem=0xC1, out_err=0, out_valid rises 8 edges after accept.
REQ-030 Same operand with STEP=3 -> out_rem=0xC1, C=3, out_valid rises 4 edges after accept; STEP=7 -> C=1, valid after 2 edges.
REQ-031 M=8, in_poly=0x00A5, modulus=0x11B -> out_rem=0xA5 after the full C-edge latency.
REQ-032 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_poly -> out_rem stays constant, in_ready=0, no second accept; in_ready rises 1 cycle after the drain handshake.
REQ-033 modulus=0x01B -> out_valid after 1 edge, out_err=1, out_rem=0.
REQ-034 rst_n pulsed low on the 3rd REDUCE edge -> outputs go to reset values immediately, out_valid never asserts for that operand, in_ready=1 after release, and the next operand (0x2B79) returns 0xC1.
